regfile_writeback: RTL and testbench

Writeback and scoreboard block that drives the write port of the 8-entry x 8-bit register file. It sits on the register file's producer side. It merges single-cycle ALU results with variable-latency load results, and buffers one load result when both arrive together. It registers the final WriteReg/WriteData/RegWrite triple and tracks pending destinations, so decode can stall on read-after-write and write-after-write hazards.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_skid_buf.sv | 50 +++++
 rtl/regfile_writeback.sv | 121 ++++++++++++
 tb/tb_regfile_writeback.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
package regfile_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/wb_skid_buf.sv
// One-entry holding buffer for a load result (dest + data).
// Handshake: a beat transfers on in_valid && in_ready, leaves on out_valid && out_ready.
module wb_skid_buf
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  reg_addr_t in_dest,
  input  reg_data_t in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output reg_addr_t out_dest,
  output reg_data_t out_data
);
  logic      full_q, full_d;
  reg_addr_t dest_q, dest_d;
  reg_data_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    if (full_q) begin
      full_d = !out_ready;
    end else if (in_valid) begin
      full_d = 1'b1;
      dest_d = in_dest;
      data_d = in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_dest  = dest_q;
  assign out_data  = data_q;
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the register-file write port and tracks pending destinations.
// Define BYPASS_EN to forward the registered write value to the hazard query.
module regfile_writeback
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      issue_valid,
  input  reg_addr_t issue_dest,
  output logic      issue_ready,
  input  reg_addr_t Read1,
  input  reg_addr_t Read2,
  output logic      stall,
  input  logic      alu_valid,
  input  reg_addr_t alu_dest,
  input  reg_data_t alu_data,
  input  logic      mem_valid,
  input  reg_addr_t mem_dest,
  input  reg_data_t mem_data,
  output logic      mem_ready,
  output reg_addr_t WriteReg,
  output reg_data_t WriteData,
  output logic      RegWrite,
  output reg_data_t bypass_data,
  output logic      bypass1_hit,
  output logic      bypass2_hit
);
  logic                reg_write_q, reg_write_d;
  reg_addr_t           write_reg_q, write_reg_d;
  reg_data_t           write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic      buf_full, buf_push, buf_pop, buf_in_ready, mem_acc;
  reg_addr_t buf_dest, sel_dest;
  reg_data_t buf_data, sel_data;
  logic      sel_valid;

  assign mem_ready = buf_in_ready;
  assign mem_acc   = mem_valid && buf_in_ready;

  wb_skid_buf u_load_buf (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (buf_push),
    .in_ready  (buf_in_ready),
    .in_dest   (mem_dest),
    .in_data   (mem_data),
    .out_valid (buf_full),
    .out_ready (buf_pop),
    .out_dest  (buf_dest),
    .out_data  (buf_data)
  );

  // ALU first, then the older buffered load, then a fresh load.
  always_comb begin
    sel_valid = 1'b0;
    sel_dest  = ZERO_REG;
    sel_data  = '0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_dest  = alu_dest;
      sel_data  = alu_data;
      buf_push  = mem_acc;
    end else if (buf_full) begin
      sel_valid = 1'b1;
      sel_dest  = buf_dest;
      sel_data  = buf_data;
      buf_pop   = 1'b1;
    end else if (mem_acc) begin
      sel_valid = 1'b1;
      sel_dest  = mem_dest;
      sel_data  = mem_data;
    end
  end

  always_comb begin
    reg_write_d  = sel_valid && (sel_dest != ZERO_REG);
    write_reg_d  = sel_valid ? sel_dest : write_reg_q;
    write_data_d = sel_valid ? sel_data : write_data_q;
  end

  // Clear on the actual register-file write, then set so a same-cycle reissue wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) busy_d[write_reg_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_dest != ZERO_REG)) busy_d[issue_dest] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign issue_ready = !busy_q[issue_dest];
  assign RegWrite    = reg_write_q;
  assign WriteReg    = write_reg_q;
  assign WriteData   = write_data_q;

`ifdef BYPASS_EN
  assign bypass_data = write_data_q;
  assign bypass1_hit = reg_write_q && (write_reg_q == Read1) && (Read1 != ZERO_REG);
  assign bypass2_hit = reg_write_q && (write_reg_q == Read2) && (Read2 != ZERO_REG);
`else
  assign bypass_data = '0;
  assign bypass1_hit = 1'b0;
  assign bypass2_hit = 1'b0;
`endif

  assign stall = (busy_q[Read1] && !bypass1_hit) || (busy_q[Read2] && !bypass2_hit);
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based writeback model.
module tb_regfile_writeback;
  import regfile_pkg::*;

  logic      clock, reset;
  logic      issue_valid, issue_ready, stall;
  reg_addr_t issue_dest, Read1, Read2;
  logic      alu_valid, mem_valid, mem_ready;
  reg_addr_t alu_dest, mem_dest, WriteReg;
  reg_data_t alu_data, mem_data, WriteData, bypass_data;
  logic      RegWrite, bypass1_hit, bypass2_hit;

  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .Read1(Read1), .Read2(Read2), .stall(stall),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .bypass_data(bypass_data), .bypass1_hit(bypass1_hit), .bypass2_hit(bypass2_hit)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  // model: accepted-but-unwritten loads as {dest,data}, busy bits, registered write triple
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  bit        m_busy[NUM_REGS];
  bit        m_rw;
  reg_addr_t m_wreg;
  reg_data_t m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
    m_rw = 0; m_wreg = '0; m_wdata = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit mem_rdy, iss_rdy, have;
    logic [ADDR_W+DATA_W-1:0] w;
    mem_rdy = (exp_q.size() == 0);
    iss_rdy = !m_busy[issue_dest];
    if (m_rw) m_busy[m_wreg] = 0;
    if (issue_valid && iss_rdy && issue_dest != 0) m_busy[issue_dest] = 1;
    if (mem_valid && mem_rdy) exp_q.push_back({mem_dest, mem_data});
    have = 1;
    if (alu_valid) w = {alu_dest, alu_data};
    else if (exp_q.size() > 0) w = exp_q.pop_front();
    else begin have = 0; w = '0; end
    m_rw = have && (w[ADDR_W+DATA_W-1:DATA_W] != 0);
    if (m_rw) begin
      m_wreg  = w[ADDR_W+DATA_W-1:DATA_W];
      m_wdata = w[DATA_W-1:0];
    end
  endtask

  // driver tasks
  task automatic set_idle();
    issue_valid = 0; issue_dest = '0; Read1 = '0; Read2 = '0;
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    mem_valid = 0; mem_dest = '0; mem_data = '0;
  endtask

  task automatic cycle();
    logic h1, h2;
    #1;
`ifdef BYPASS_EN
    h1 = m_rw && (m_wreg == Read1) && (Read1 != 0);
    h2 = m_rw && (m_wreg == Read2) && (Read2 != 0);
    if (m_rw) check("bypass_data", bypass_data, m_wdata);
`else
    h1 = 0; h2 = 0;
    check("bypass_data", bypass_data, 0);
`endif
    check("bypass1_hit", bypass1_hit, h1);
    check("bypass2_hit", bypass2_hit, h2);
    check("stall", stall, (m_busy[Read1] && !h1) || (m_busy[Read2] && !h2));
    check("issue_ready", issue_ready, !m_busy[issue_dest]);
    check("mem_ready", mem_ready, exp_q.size() == 0);
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("RegWrite", RegWrite, m_rw);
    if (m_rw) begin
      check("WriteReg", WriteReg, m_wreg);
      check("WriteData", WriteData, m_wdata);
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;

    check("rst_RegWrite", RegWrite, 0);
    check("rst_WriteReg", WriteReg, 0);
    check("rst_WriteData", WriteData, 0);
    check("rst_mem_ready", mem_ready, 1);

    // ALU write to a pending register
    issue_valid = 1; issue_dest = 3; cycle();
    set_idle(); Read1 = 3; alu_valid = 1; alu_dest = 3; alu_data = 8'hA5; cycle();
    check("alu_rw", RegWrite, 1);
    check("alu_wreg", WriteReg, 3);
    check("alu_wdata", WriteData, 8'hA5);
    set_idle(); Read1 = 3; cycle();
    check("alu_stall_clear", stall, 0);

    // ALU/load collision, then a second load held off by the full buffer
    set_idle(); alu_valid = 1; alu_dest = 2; alu_data = 8'h11;
    mem_valid = 1; mem_dest = 5; mem_data = 8'h22; cycle();
    check("col_first", {WriteReg, WriteData}, {3'd2, 8'h11});
    set_idle(); mem_valid = 1; mem_dest = 1; mem_data = 8'h33;
    #1 check("col_mem_ready", mem_ready, 0);
    cycle();
    check("col_second", {WriteReg, WriteData}, {3'd5, 8'h22});
    cycle();
    check("col_third", {WriteReg, WriteData}, {3'd1, 8'h33});
    set_idle(); cycle();
    check("idle_hold", {RegWrite, WriteReg, WriteData}, {1'b0, 3'd1, 8'h33});

    // destination zero
    set_idle(); alu_valid = 1; alu_dest = 0; alu_data = 8'hFF; issue_valid = 1; issue_dest = 0; cycle();
    check("dest0_rw", RegWrite, 0);
    set_idle(); issue_valid = 1; issue_dest = 0;
    #1 check("dest0_issue_ready", issue_ready, 1);
    cycle();

    // WAW and same-cycle set/clear
    set_idle(); issue_valid = 1; issue_dest = 4; cycle();
    #1 check("waw_issue_ready", issue_ready, 0);
    cycle();
    set_idle(); alu_valid = 1; alu_dest = 4; alu_data = 8'h44; cycle();
    set_idle(); alu_valid = 1; alu_dest = 4; alu_data = 8'h45; cycle();
    set_idle(); issue_valid = 1; issue_dest = 4; cycle();
    set_idle(); Read1 = 4;
    #1 check("setwins_stall", stall, 1);
    cycle();
    set_idle(); alu_valid = 1; alu_dest = 4; alu_data = 8'h46; cycle();
    set_idle(); cycle();

    // forwarding of a just-written register
    set_idle(); issue_valid = 1; issue_dest = 6; cycle();
    set_idle(); alu_valid = 1; alu_dest = 6; alu_data = 8'h3C; cycle();
    set_idle(); Read2 = 6;
    #1;
`ifdef BYPASS_EN
    check("bp_hit2", bypass2_hit, 1);
    check("bp_data", bypass_data, 8'h3C);
    check("bp_stall", stall, 0);
`else
    check("nobp_stall", stall, 1);
`endif
    cycle();

    // asynchronous reset with a buffered load and a pending write
    set_idle(); issue_valid = 1; issue_dest = 3; cycle();
    set_idle(); alu_valid = 1; alu_dest = 2; alu_data = 8'h11;
    mem_valid = 1; mem_dest = 5; mem_data = 8'h22; cycle();
    set_idle(); Read1 = 3; issue_dest = 3;
    #2 reset = 1;
    #1;
    check("arst_RegWrite", RegWrite, 0);
    check("arst_mem_ready", mem_ready, 1);
    check("arst_stall", stall, 0);
    check("arst_issue_ready", issue_ready, 1);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_dest  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      Read1       = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      Read2       = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_dest    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      alu_data    = reg_data_t'($urandom_range(0, 255));
      mem_valid   = ($urandom_range(0, 2) == 0);
      mem_dest    = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      mem_data    = reg_data_t'($urandom_range(0, 255));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
